// File: rtl/led_level_ctrl.sv
// led_level_ctrl
// ---------------------------------------------------------------------------
// Brightness-level controller for the LED PWM path. The debounced UP/DOWN
// button levels are edge-detected in the clk_25mhz domain and step a target
// brightness, either saturating or wrapping at the ends. Holding a button
// auto-repeats after an initial delay. The level bus that feeds pwmGenerator
// either follows the target directly or ramps toward it one LSB at a time.
// Nothing in here is clocked by a button signal.
//
// Parameters:
//   LEVEL_W       width of the level bus into pwmGenerator
//   REPEAT_DELAY  cycles a button must be held before auto-repeat starts
//   REPEAT_RATE   cycles between auto-repeat steps
//   FADE_STEP     cycles per one-LSB move of level in fade mode
//   WRAP          1 = wrap at max/min, 0 = saturate
//
// Ports:
//   clk_25mhz     system clock
//   rst_n         asynchronous active-low reset
//   up, down      debounced button levels, synchronous to clk_25mhz
//   fade_en       1 = level ramps toward target_level, 0 = level follows it
//   target_level  requested brightness
//   level         brightness applied to pwmGenerator
//   at_max        target_level is all ones
//   at_min        target_level is zero
//   busy          level differs from target_level
// ---------------------------------------------------------------------------
module led_level_ctrl #(
    parameter int LEVEL_W      = 4,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 2_500_000,
    parameter int FADE_STEP    = 1_250_000,
    parameter int WRAP         = 0
) (
    input  logic               clk_25mhz,
    input  logic               rst_n,
    input  logic               up,
    input  logic               down,
    input  logic               fade_en,
    output logic [LEVEL_W-1:0] target_level,
    output logic [LEVEL_W-1:0] level,
    output logic               at_max,
    output logic               at_min,
    output logic               busy
);

    // The repeat counter is shared by the delay and rate phases, so it is
    // sized for the larger of the two reload values.
    localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int FADE_W   = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

    localparam logic [RPT_W-1:0]   DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]   RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [FADE_W-1:0]  FADE_LOAD  = FADE_W'(FADE_STEP - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } RepeatState;

    RepeatState        state;
    logic              upQ;
    logic              downQ;
    logic              armed;
    logic              lockout;
    logic              dirUp;
    logic [RPT_W-1:0]  rptCnt;
    logic [FADE_W-1:0] fadeCnt;

    logic              upPress;
    logic              downPress;
    logic              dirHeld;
    logic              oppHeld;

    // One step of the target in either direction. At the ends the step is
    // either a no-op (saturate) or rolls over modulo 2^LEVEL_W (wrap).
    function automatic logic [LEVEL_W-1:0] stepLevel(input logic [LEVEL_W-1:0] cur,
                                                     input logic goUp);
        if (goUp) begin
            if ((cur == LEVEL_MAX) && (WRAP == 0)) begin
                return cur;
            end
            return cur + LEVEL_W'(1);
        end
        if ((cur == '0) && (WRAP == 0)) begin
            return cur;
        end
        return cur - LEVEL_W'(1);
    endfunction

    // A press is a low-to-high transition between consecutive samples. The
    // armed flag suppresses detection on the first edge after reset so that
    // a button already held while in reset is not taken as a press.
    assign upPress   = armed & up & ~upQ;
    assign downPress = armed & down & ~downQ;

    // While repeating, dirHeld is the button that started the hold and
    // oppHeld is the other one.
    assign dirHeld   = dirUp ? up : down;
    assign oppHeld   = dirUp ? down : up;

    // Previous-sample registers for edge detection, plus the post-reset
    // arming flag.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            upQ   <= 1'b0;
            downQ <= 1'b0;
            armed <= 1'b0;
        end else begin
            upQ   <= up;
            downQ <= down;
            armed <= 1'b1;
        end
    end

    // Repeat FSM and the target register. A clean press steps once and
    // starts the hold delay. Once the delay expires, steps follow at the
    // repeat rate until the held button is released. If the opposite button
    // comes up during a hold, the hold is abandoned without a step, and the
    // lockout flag ignores all presses until both buttons are low again.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dirUp        <= 1'b0;
            lockout      <= 1'b0;
            rptCnt       <= DELAY_LOAD;
            target_level <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lockout) begin
                        if (!up && !down) begin
                            lockout <= 1'b0;
                        end
                    end else if (upPress && !down) begin
                        target_level <= stepLevel(target_level, 1'b1);
                        dirUp        <= 1'b1;
                        rptCnt       <= DELAY_LOAD;
                        state        <= DELAY;
                    end else if (downPress && !up) begin
                        target_level <= stepLevel(target_level, 1'b0);
                        dirUp        <= 1'b0;
                        rptCnt       <= DELAY_LOAD;
                        state        <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (oppHeld) begin
                        lockout <= 1'b1;
                        state   <= IDLE;
                    end else if (!dirHeld) begin
                        state <= IDLE;
                    end else if (rptCnt == '0) begin
                        target_level <= stepLevel(target_level, dirUp);
                        rptCnt       <= RATE_LOAD;
                        state        <= REPEAT;
                    end else begin
                        rptCnt <= rptCnt - RPT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Level path. With fade disabled, level copies the target one edge
    // later. With fade enabled, the fade counter runs only while level and
    // target differ, and each expiry moves level one LSB toward the current
    // target. A target change mid-ramp only changes the direction and does
    // not restart the counter.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            level   <= '0;
            fadeCnt <= FADE_LOAD;
        end else if (!fade_en) begin
            level   <= target_level;
            fadeCnt <= FADE_LOAD;
        end else if (!busy) begin
            fadeCnt <= FADE_LOAD;
        end else if (fadeCnt == '0) begin
            level   <= (level < target_level) ? level + LEVEL_W'(1) : level - LEVEL_W'(1);
            fadeCnt <= FADE_LOAD;
        end else begin
            fadeCnt <= fadeCnt - FADE_W'(1);
        end
    end

    // Status flags are decoded from registers only, so they cannot glitch
    // on button activity.
    assign at_max = (target_level == LEVEL_MAX);
    assign at_min = (target_level == '0);
    assign busy   = (level != target_level);

endmodule

// File: tb/tb_led_level_ctrl.sv
// tb_led_level_ctrl
// ---------------------------------------------------------------------------
// Testbench for led_level_ctrl. A saturating instance and a wrapping
// instance share the same stimulus. A behavioural model describes the
// controller by elapsed hold time and elapsed fade time. It is compared
// against both instances on every falling clock edge. Directed scenarios
// pin the model with literal values, and a randomised phase follows.
// ---------------------------------------------------------------------------
module tb_led_level_ctrl;

    localparam int LW   = 4;
    localparam int RD   = 8;
    localparam int RR   = 4;
    localparam int FS   = 3;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          up = 1'b0;
    logic          down = 1'b0;
    logic          fadeEn = 1'b0;

    logic [LW-1:0] targetSat, levelSat, targetWrap, levelWrap;
    logic          atMaxSat, atMinSat, busySat;
    logic          atMaxWrap, atMinWrap, busyWrap;

    int            testsRun = 0;
    int            testsFailed = 0;
    bit            checkEn = 1'b0;

    // Model state: index 0 models the saturating DUT, index 1 the wrapping one
    int            mTarget [2];
    int            mLevel [2];
    int            mFadeWait [2];
    bit            mPrevU, mPrevD, mArmed, mNeedRelease;
    int            mHoldDir;
    int            mHoldCnt;

    led_level_ctrl #(
        .LEVEL_W(LW), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FADE_STEP(FS), .WRAP(0)
    ) uSat (
        .clk_25mhz(clk), .rst_n(rst_n), .up(up), .down(down), .fade_en(fadeEn),
        .target_level(targetSat), .level(levelSat),
        .at_max(atMaxSat), .at_min(atMinSat), .busy(busySat)
    );

    led_level_ctrl #(
        .LEVEL_W(LW), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FADE_STEP(FS), .WRAP(1)
    ) uWrap (
        .clk_25mhz(clk), .rst_n(rst_n), .up(up), .down(down), .fade_en(fadeEn),
        .target_level(targetWrap), .level(levelWrap),
        .at_max(atMaxWrap), .at_min(atMinWrap), .busy(busyWrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int applyStep(input int t, input int dir, input int wrap);
        int n;
        n = t + dir;
        if (wrap != 0) return (n + LMAX + 1) % (LMAX + 1);
        if (n > LMAX) return LMAX;
        if (n < 0) return 0;
        return n;
    endfunction

    task automatic modelReset();
        for (int w = 0; w < 2; w++) begin
            mTarget[w]   = 0;
            mLevel[w]    = 0;
            mFadeWait[w] = 0;
        end
        mPrevU       = 1'b0;
        mPrevD       = 1'b0;
        mArmed       = 1'b0;
        mNeedRelease = 1'b0;
        mHoldDir     = 0;
        mHoldCnt     = 0;
    endtask

    // One clock edge of the model. A hold is tracked as the number of edges
    // since the press. Steps fall at zero, at RD, and every RR edges after RD.
    // Fade is tracked as edges spent waiting since the last move or the
    // start of the difference.
    task automatic modelStep();
        bit pressU, pressD, heldDir, heldOpp;
        int stepDir, oldT;
        pressU  = mArmed && up && !mPrevU;
        pressD  = mArmed && down && !mPrevD;
        stepDir = 0;
        if (mHoldDir != 0) begin
            heldDir = (mHoldDir > 0) ? up : down;
            heldOpp = (mHoldDir > 0) ? down : up;
            if (heldOpp) begin
                mHoldDir     = 0;
                mNeedRelease = 1'b1;
            end else if (!heldDir) begin
                mHoldDir = 0;
            end else begin
                mHoldCnt++;
                if (mHoldCnt == RD || (mHoldCnt > RD && ((mHoldCnt - RD) % RR) == 0))
                    stepDir = mHoldDir;
            end
        end else if (mNeedRelease) begin
            if (!up && !down) mNeedRelease = 1'b0;
        end else if (pressU && !down) begin
            stepDir  = 1;
            mHoldDir = 1;
            mHoldCnt = 0;
        end else if (pressD && !up) begin
            stepDir  = -1;
            mHoldDir = -1;
            mHoldCnt = 0;
        end
        for (int w = 0; w < 2; w++) begin
            oldT = mTarget[w];
            if (stepDir != 0) mTarget[w] = applyStep(oldT, stepDir, w);
            if (!fadeEn) begin
                mLevel[w]    = oldT;
                mFadeWait[w] = 0;
            end else if (mLevel[w] == oldT) begin
                mFadeWait[w] = 0;
            end else begin
                mFadeWait[w]++;
                if (mFadeWait[w] == FS) begin
                    mLevel[w]    = mLevel[w] + ((oldT > mLevel[w]) ? 1 : -1);
                    mFadeWait[w] = 0;
                end
            end
        end
        mPrevU = up;
        mPrevD = down;
        mArmed = 1'b1;
    endtask

    // Model advances on the same edges as the DUT, including async reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else modelStep();
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("targetSat", targetSat, mTarget[0]);
            checkOutput("levelSat", levelSat, mLevel[0]);
            checkOutput("atMaxSat", atMaxSat, mTarget[0] == LMAX);
            checkOutput("atMinSat", atMinSat, mTarget[0] == 0);
            checkOutput("busySat", busySat, mLevel[0] != mTarget[0]);
            checkOutput("targetWrap", targetWrap, mTarget[1]);
            checkOutput("levelWrap", levelWrap, mLevel[1]);
            checkOutput("atMaxWrap", atMaxWrap, mTarget[1] == LMAX);
            checkOutput("atMinWrap", atMinWrap, mTarget[1] == 0);
            checkOutput("busyWrap", busyWrap, mLevel[1] != mTarget[1]);
        end
    end

    task automatic applyStimulus(input bit u, input bit d, input bit f, input int cycles);
        up     = u;
        down   = d;
        fadeEn = f;
        repeat (cycles) @(negedge clk);
    endtask

    // Reset asserted away from the clock edge and released on a falling
    // edge. The buttons keep whatever level the caller leaves them at.
    task automatic resetDut();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstTarget", targetSat, 0);
        checkOutput("rstLevel", levelSat, 0);
        checkOutput("rstAtMin", atMinSat, 1);
        checkOutput("rstAtMax", atMaxSat, 0);
        checkOutput("rstBusy", busySat, 0);
        checkOutput("rstTargetWrap", targetWrap, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        bit curFade;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("initAtMin", atMinSat, 1);
        checkOutput("initBusy", busySat, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        checkEn = 1'b1;

        // Scenario 1: five short UP pulses, then six DOWN pulses into saturation
        applyStimulus(0, 0, 0, 2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 3);
            applyStimulus(0, 0, 0, 3);
        end
        checkOutput("s1Target", targetSat, 5);
        checkOutput("s1Level", levelSat, 5);
        checkOutput("s1Model", mTarget[0], 5);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 3);
            applyStimulus(0, 0, 0, 3);
        end
        checkOutput("s1Floor", targetSat, 0);
        checkOutput("s1AtMin", atMinSat, 1);

        // Scenario 2: 30-cycle hold gives steps at k, k+8, then every 4 edges
        applyStimulus(1, 0, 0, 30);
        applyStimulus(0, 0, 0, 10);
        checkOutput("s2Target", targetSat, 7);
        checkOutput("s2Model", mTarget[0], 7);

        // Scenario 3: opposite button during a hold aborts without a step
        resetDut();
        applyStimulus(0, 0, 0, 2);
        applyStimulus(1, 0, 0, 5);
        applyStimulus(1, 1, 0, 10);
        checkOutput("s3Both", targetSat, 1);
        applyStimulus(0, 1, 0, 4);
        checkOutput("s3Lockout", targetSat, 1);
        applyStimulus(0, 0, 0, 3);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 0, 3);
        checkOutput("s3Down", targetSat, 0);

        // Scenario 4: reach 15 by long hold, then step past the ends
        resetDut();
        applyStimulus(0, 0, 0, 2);
        applyStimulus(1, 0, 0, 61);
        applyStimulus(0, 0, 0, 3);
        checkOutput("s4SatTop", targetSat, 15);
        checkOutput("s4WrapTop", targetWrap, 15);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, 3);
        checkOutput("s4WrapUp", targetWrap, 0);
        checkOutput("s4SatUp", targetSat, 15);
        checkOutput("s4SatAtMax", atMaxSat, 1);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 0, 3);
        checkOutput("s4WrapDown", targetWrap, 15);
        checkOutput("s4SatDown", targetSat, 14);

        // Scenario 5: fade ramp to 4, then a second ramp cut short by fade_en
        resetDut();
        applyStimulus(0, 0, 1, 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 1);
            applyStimulus(0, 0, 1, 1);
        end
        checkOutput("s5Ramping", busySat, 1);
        waited = 0;
        while ((levelSat != 4 || busySat) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("s5Timeout", waited < 40, 1);
        checkOutput("s5Level", levelSat, 4);
        checkOutput("s5ModelLevel", mLevel[0], 4);
        checkOutput("s5Busy", busySat, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 1);
            applyStimulus(0, 0, 1, 1);
        end
        applyStimulus(0, 0, 1, 1);
        checkOutput("s5MidRamp", levelSat < 8, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("s5Jump", levelSat, 8);
        checkOutput("s5JumpBusy", busySat, 0);

        // Scenario 6: reset during auto-repeat with UP still held
        resetDut();
        applyStimulus(0, 0, 0, 2);
        applyStimulus(1, 0, 0, 20);
        checkOutput("s6Repeat", targetSat, 4);
        resetDut();
        applyStimulus(1, 0, 0, 6);
        checkOutput("s6HeldAtRelease", targetSat, 0);
        applyStimulus(0, 0, 0, 2);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, 1);
        checkOutput("s6NewPress", targetSat, 1);

        // Random phase: button holds of random length, fade toggles, resets
        curFade = 1'b0;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 99) < 3) begin
                resetDut();
            end else begin
                if ($urandom_range(0, 7) == 0) curFade = ~curFade;
                applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                              curFade, $urandom_range(1, 20));
            end
        end
        applyStimulus(0, 0, 0, 4);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
